// File: rtl/cpu_icache_if.sv
// Fetch-side and memory-side signal bundle of the L1 instruction cache.
// slave = cache side, master = fetch/memory side.
interface cpu_icache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  flush;
  logic                  resp_valid;
  logic [WORD_WIDTH-1:0] resp_word;
  logic                  stall;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [WORD_WIDTH-1:0] mem_resp_data;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output resp_valid, resp_word, stall, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  resp_valid, resp_word, stall, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/cpu_icache.sv
// Direct-mapped read-only L1 instruction cache: 1-cycle hits, whole-line refill on miss.
// Define ICACHE_PERF_EN to add the o_perf_hits / o_perf_misses counters.
module cpu_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  cpu_icache_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] o_perf_hits,
  output logic [31:0] o_perf_misses
`endif
);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int IDX_LSB = 2 + OFF_W;
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REFILL, S_RESP} state_t;

  state_t r_state, w_state_next;

  logic [NUM_LINES-1:0]  r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_LINES];
  logic [WORD_WIDTH-1:0] r_data [NUM_LINES*LINE_WORDS];

  logic [ADDR_WIDTH-3:0] r_addr;
  logic [OFF_W-1:0]      r_count;
  logic                  r_abort;
  logic                  r_resp_valid;
  logic [WORD_WIDTH-1:0] r_resp_word;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [OFF_W-1:0] w_miss_off;
  logic [IDX_W-1:0] w_miss_idx;
  logic [TAG_W-1:0] w_miss_tag;
  logic             w_hit;
  logic             w_accept;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_drop;
  logic             w_stall;
  logic             w_mem_req_valid;

  assign w_off      = bus.req_addr[2 +: OFF_W];
  assign w_idx      = bus.req_addr[IDX_LSB +: IDX_W];
  assign w_tag      = bus.req_addr[TAG_LSB +: TAG_W];
  assign w_miss_off = r_addr[0 +: OFF_W];
  assign w_miss_idx = r_addr[OFF_W +: IDX_W];
  assign w_miss_tag = r_addr[OFF_W+IDX_W +: TAG_W];

  // A flush in the same cycle as a request forces that request to miss.
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !bus.flush;
  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_beat      = (r_state == S_REFILL) && bus.mem_resp_valid;
  assign w_last_beat = w_beat && (r_count == OFF_W'(LINE_WORDS-1));
  assign w_drop      = r_abort || bus.flush;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_stall         = 1'b1;
    w_mem_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = bus.req_valid && !w_hit;
        if (bus.req_valid && !w_hit) w_state_next = S_REQ;
      end
      S_REQ: begin
        w_mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_state_next = S_REFILL;
      end
      S_REFILL: begin
        if (w_last_beat) w_state_next = w_drop ? S_IDLE : S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid      <= '0;
      r_addr       <= '0;
      r_count      <= '0;
      r_abort      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_word  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        if (w_hit) begin
          r_resp_valid <= 1'b1;
          r_resp_word  <= r_data[{w_idx, w_off}];
        end else begin
          r_addr <= bus.req_addr[ADDR_WIDTH-1:2];
        end
      end

      if (r_state == S_REQ && bus.mem_req_ready) r_count <= '0;
      // The missed word is captured as it streams past, so RESP needs no array read.
      if (w_beat) begin
        r_count <= r_count + 1'b1;
        if (r_count == w_miss_off) r_resp_word <= bus.mem_resp_data;
        if (w_last_beat && !w_drop) r_resp_valid <= 1'b1;
      end

      if (r_state == S_IDLE) r_abort <= 1'b0;
      else if (bus.flush && (r_state == S_REQ || r_state == S_REFILL)) r_abort <= 1'b1;

      if (bus.flush) begin
        r_valid <= '0;
      end else if (w_beat) begin
        if (r_count == '0) r_valid[w_miss_idx] <= 1'b0;
        if (w_last_beat && !r_abort) r_valid[w_miss_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_beat) begin
      r_data[{w_miss_idx, r_count}] <= bus.mem_resp_data;
      if (r_count == '0) r_tag[w_miss_idx] <= w_miss_tag;
    end
  end

  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_word     = r_resp_word;
  assign bus.stall         = w_stall;
  assign bus.mem_req_valid = w_mem_req_valid;
  assign bus.mem_req_addr  = {r_addr[ADDR_WIDTH-3:OFF_W], {(OFF_W+2){1'b0}}};

`ifdef ICACHE_PERF_EN
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_misses;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
    end else if (w_accept) begin
      if (w_hit) r_perf_hits   <= r_perf_hits + 32'd1;
      else       r_perf_misses <= r_perf_misses + 32'd1;
    end
  end

  assign o_perf_hits   = r_perf_hits;
  assign o_perf_misses = r_perf_misses;
`endif
endmodule

// File: tb/tb_cpu_icache.sv
// Bench for cpu_icache: vector table of fetch requests plus hand-written refill corner cases,
// with a memory responder and a response scoreboard.
module tb_cpu_icache;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_icache_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  cpu_icache #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WORDS(LW), .NUM_LINES(4)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .bus           (bus)
`ifdef ICACHE_PERF_EN
    ,
    .o_perf_hits   (perf_hits),
    .o_perf_misses (perf_misses)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_resp = 0;
  int resp_cyc = 0;
  int beats = 0;
  int beats_sent = 0;
  int mem_reqs = 0;
  bit gap_en = 1'b0;
  logic [31:0] rbase = '0;
  logic [31:0] last_req_addr = '0;
  logic [31:0] sb[$];
  int mdl_hits = 0;
  int mdl_misses = 0;

  typedef struct {
    logic [31:0] addr;
    bit          fl;
    bit          hit;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[15];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: accepts a refill request, then streams the line one beat per cycle.
  initial begin
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beats = 0;
        bus.mem_resp_valid = 1'b0;
      end else begin
        if (beats > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mem_word(rbase + 32'((LW - beats) * 4));
          beats--;
          beats_sent++;
        end else begin
          bus.mem_resp_valid = 1'b0;
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          mem_reqs++;
          last_req_addr = bus.mem_req_addr;
          rbase = bus.mem_req_addr;
          beats = LW;
        end
      end
    end
  end

  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid) begin
        n_resp++;
        resp_cyc = cyc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got %h required no response", bus.resp_word);
        end else begin
          exp = sb.pop_front();
          check("resp_word", bus.resp_word, exp);
        end
      end
    end
  end

  task automatic wait_resp(input int n0, output bit got);
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk); #1;
      if (n_resp != n0) got = 1'b1;
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input bit fl, input bit exp_hit,
                        input logic [31:0] word, input bit chk_lat);
    int q, n0, m0;
    bit got;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.flush     = fl;
    @(negedge clk);
    q = cyc; n0 = n_resp; m0 = mem_reqs;
    check("stall", 32'(bus.stall), 32'(!exp_hit));
    sb.push_back(word);
    if (exp_hit) mdl_hits++; else mdl_misses++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    wait_resp(n0, got);
    check("resp_timeout", 32'(got), 32'd1);
    if (got && chk_lat) check("latency", 32'(resp_cyc - q), exp_hit ? 32'd1 : 32'(2 + LW));
    check("mem_req_count", 32'(mem_reqs - m0), exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) check("mem_req_addr", last_req_addr, addr & ~32'hF);
    $display("[TB] req addr=%h flush=%0d hit=%0d word=%h lat=%0d", addr, fl, exp_hit, word, resp_cyc - q);
  endtask

  task automatic start_miss(input logic [31:0] addr);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(negedge clk);
    check("stall_miss", 32'(bus.stall), 32'd1);
    mdl_misses++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      if (beats_sent >= target) ok = 1'b1;
    end
    check("beat_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int b0, n0;
    bit got;
    vecs[0]  = '{32'h000, 1'b0, 1'b0, 32'hA0};
    vecs[1]  = '{32'h004, 1'b0, 1'b1, 32'hA1};
    vecs[2]  = '{32'h00C, 1'b0, 1'b1, 32'hA3};
    vecs[3]  = '{32'h040, 1'b0, 1'b0, 32'hB0};
    vecs[4]  = '{32'h048, 1'b0, 1'b1, 32'hB2};
    vecs[5]  = '{32'h000, 1'b0, 1'b0, 32'hA0};
    vecs[6]  = '{32'h014, 1'b0, 1'b0, 32'hA5};
    vecs[7]  = '{32'h018, 1'b0, 1'b1, 32'hA6};
    vecs[8]  = '{32'h100, 1'b0, 1'b0, 32'hE0};
    vecs[9]  = '{32'h010, 1'b0, 1'b1, 32'hA4};
    vecs[10] = '{32'h03C, 1'b0, 1'b0, 32'hAF};
    vecs[11] = '{32'h030, 1'b1, 1'b0, 32'hAC};
    vecs[12] = '{32'h034, 1'b0, 1'b1, 32'hAD};
    vecs[13] = '{32'h014, 1'b0, 1'b0, 32'hA5};
    vecs[14] = '{32'h100, 1'b0, 1'b0, 32'hE0};

    bus.req_valid     = 1'b0;
    bus.req_addr      = '0;
    bus.flush         = 1'b0;
    bus.mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_word", bus.resp_word, 32'd0);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);

    for (int i = 0; i < 15; i++) do_req(vecs[i].addr, vecs[i].fl, vecs[i].hit, vecs[i].word, 1'b1);

    // Backpressure on the refill request, then a refill with idle beats.
    gap_en = 1'b1;
    bus.mem_req_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h200;
    @(negedge clk);
    n0 = n_resp;
    check("bp_stall0", 32'(bus.stall), 32'd1);
    sb.push_back(32'h120);
    mdl_misses++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("bp_mem_req_addr", bus.mem_req_addr, 32'h200);
      check("bp_stall", 32'(bus.stall), 32'd1);
    end
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b1;
    wait_resp(n0, got);
    check("bp_resp_timeout", 32'(got), 32'd1);
    check("bp_req_addr", last_req_addr, 32'h200);
    $display("[TB] backpressure refill addr=00000200 done");
    gap_en = 1'b0;

    // Flush after beat 1: line drained, no response, back to IDLE.
    b0 = beats_sent;
    n0 = n_resp;
    start_miss(32'h000);
    wait_beats(b0 + 2);
    @(posedge clk); #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("flush_beats", 32'(beats_sent - b0), 32'd4);
    check("flush_no_resp", 32'(n_resp - n0), 32'd0);
    check("flush_idle_stall", 32'(bus.stall), 32'd0);
    $display("[TB] flush mid-refill addr=00000000 done");
    do_req(32'h000, 1'b0, 1'b0, 32'hA0, 1'b1);

    // Reset after beat 2.
    b0 = beats_sent;
    start_miss(32'h080);
    wait_beats(b0 + 3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mdl_hits = 0;
    mdl_misses = 0;
    @(negedge clk);
    check("mrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mrst_resp_word", bus.resp_word, 32'd0);
    check("mrst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("mrst_mem_req_addr", bus.mem_req_addr, 32'd0);
    check("mrst_stall", 32'(bus.stall), 32'd0);
    $display("[TB] reset mid-refill addr=00000080 done");

    do_req(32'h004, 1'b0, 1'b0, 32'hA1, 1'b1);
    do_req(32'h008, 1'b0, 1'b1, 32'hA2, 1'b1);
    do_req(32'h00C, 1'b0, 1'b1, 32'hA3, 1'b1);
    do_req(32'h044, 1'b0, 1'b0, 32'hB1, 1'b1);
`ifdef ICACHE_PERF_EN
    @(negedge clk);
    check("perf_hits", perf_hits, 32'(mdl_hits));
    check("perf_misses", perf_misses, 32'(mdl_misses));
    check("perf_hits_const", perf_hits, 32'd2);
    check("perf_misses_const", perf_misses, 32'd2);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
